// File: rtl/spi_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer_if
//
// Bundles the host write handshake and the shared converter command bus
// that spi_cmd_sequencer owns.
//
//   host_req_in        level request for a host register write
//   host_sel_in  [1:0] target: 0=ADC1, 1=ADC2, 2=DAC1, 3=reserved
//   host_addr_in[15:0] register address
//   host_data_in[15:0] register data
//   host_ack_out       one-cycle pulse when a request is consumed
//   adc1/adc2/dac1_cmd_trig_out  one-cycle trigger to each converter driver
//   cmd_addr_out[15:0] shared, registered command address
//   cmd_data_out[15:0] shared, registered command data
//   busy_out           sequencer is not idle
//   init_done_out      sticky flag, power-up table has been replayed
//   err_out            one-cycle pulse on a request to the reserved target
//
// Modports:
//   master - host/config side (drives requests, observes everything else)
//   slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface spi_cmd_sequencer_if;

    logic        host_req_in;
    logic [1:0]  host_sel_in;
    logic [15:0] host_addr_in;
    logic [15:0] host_data_in;
    logic        host_ack_out;
    logic        adc1_cmd_trig_out;
    logic        adc2_cmd_trig_out;
    logic        dac1_cmd_trig_out;
    logic [15:0] cmd_addr_out;
    logic [15:0] cmd_data_out;
    logic        busy_out;
    logic        init_done_out;
    logic        err_out;

    modport master (
        output host_req_in,
        output host_sel_in,
        output host_addr_in,
        output host_data_in,
        input  host_ack_out,
        input  adc1_cmd_trig_out,
        input  adc2_cmd_trig_out,
        input  dac1_cmd_trig_out,
        input  cmd_addr_out,
        input  cmd_data_out,
        input  busy_out,
        input  init_done_out,
        input  err_out
    );

    modport slave (
        input  host_req_in,
        input  host_sel_in,
        input  host_addr_in,
        input  host_data_in,
        output host_ack_out,
        output adc1_cmd_trig_out,
        output adc2_cmd_trig_out,
        output dac1_cmd_trig_out,
        output cmd_addr_out,
        output cmd_data_out,
        output busy_out,
        output init_done_out,
        output err_out
    );

endinterface

// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Owns the SPI command ports of the two LTC2195 ADC drivers and the AD9783
// DAC driver. After reset it waits INIT_DELAY cycles, replays a fixed
// four-entry power-up register table (one trigger every SPI_WAIT+1 cycles),
// then serialises host register writes onto the shared command bus, one
// transaction at a time with an SPI_WAIT hold-off after each trigger.
//
// Ports:
//   clk_in  system clock (100 MHz BUFG domain)
//   rst_in  synchronous, active-high reset
//   bus     spi_cmd_sequencer_if.slave (host handshake + command bus)
//
// Parameters:
//   INIT_DELAY  cycles to wait after reset release before the first table write
//   SPI_WAIT    hold-off cycles after each trigger (must be >= 1)
// -----------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter logic [15:0] INIT_DELAY = 16'd100,
    parameter logic [15:0] SPI_WAIT   = 16'd2000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    spi_cmd_sequencer_if.slave   bus
);

    localparam logic [2:0] ST_DELAY = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_IDLE  = 3'd3;
    localparam logic [2:0] ST_HWAIT = 3'd4;

    localparam logic [1:0] SEL_ADC1 = 2'd0;
    localparam logic [1:0] SEL_ADC2 = 2'd1;
    localparam logic [1:0] SEL_DAC1 = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    localparam logic [1:0] LAST_ENTRY = 2'd3;

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [2:0]  trig;
    logic        ack;
    logic        err;
    logic        init_done;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_data;

    logic [1:0]  issue_idx;
    logic [33:0] issue_entry;
    logic [1:0]  issue_sel;
    logic [15:0] issue_addr;
    logic [15:0] issue_data;

    // Power-up table packed as {target, addr, data}.
    function automatic logic [33:0] table_entry(input logic [1:0] i);
        logic [33:0] e;
        case (i)
            2'd0:    e = {SEL_ADC1, 16'h0000, 16'h0080};
            2'd1:    e = {SEL_ADC2, 16'h0000, 16'h0080};
            2'd2:    e = {SEL_ADC1, 16'h0003, 16'h0001};
            default: e = {SEL_DAC1, 16'h0000, 16'h0020};
        endcase
        return e;
    endfunction

    // One-hot trigger vector {dac1, adc2, adc1} for a target code.
    function automatic logic [2:0] trig_for(input logic [1:0] sel);
        logic [2:0] t;
        case (sel)
            SEL_ADC1: t = 3'b001;
            SEL_ADC2: t = 3'b010;
            SEL_DAC1: t = 3'b100;
            default:  t = 3'b000;
        endcase
        return t;
    endfunction

    // The trigger and command word are registered on the edge that enters
    // ISSUE, so the table entry needed is the one about to be issued: the
    // current index from DELAY, the next index when leaving WAIT.
    always_comb begin
        issue_idx   = (state == ST_WAIT) ? idx + 2'd1 : idx;
        issue_entry = table_entry(issue_idx);
        issue_sel   = issue_entry[33:32];
        issue_addr  = issue_entry[31:16];
        issue_data  = issue_entry[15:0];
    end

    // Main sequencer. Pulse outputs default low every cycle; each state
    // raises them only on the edge that starts a transaction. DELAY compares
    // against INIT_DELAY (not INIT_DELAY-1) because the cycle right after the
    // reset edge is already spent in DELAY with the counter at zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= ST_DELAY;
            cnt       <= 16'd0;
            idx       <= 2'd0;
            trig      <= 3'b000;
            ack       <= 1'b0;
            err       <= 1'b0;
            init_done <= 1'b0;
            cmd_addr  <= 16'd0;
            cmd_data  <= 16'd0;
        end else begin
            trig <= 3'b000;
            ack  <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_DELAY: begin
                    if (cnt == INIT_DELAY) begin
                        state    <= ST_ISSUE;
                        cnt      <= 16'd0;
                        trig     <= trig_for(issue_sel);
                        cmd_addr <= issue_addr;
                        cmd_data <= issue_data;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                    cnt   <= 16'd0;
                end
                ST_WAIT: begin
                    if (cnt == SPI_WAIT - 16'd1) begin
                        cnt <= 16'd0;
                        if (idx == LAST_ENTRY) begin
                            state     <= ST_IDLE;
                            init_done <= 1'b1;
                        end else begin
                            idx      <= issue_idx;
                            state    <= ST_ISSUE;
                            trig     <= trig_for(issue_sel);
                            cmd_addr <= issue_addr;
                            cmd_data <= issue_data;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_IDLE: begin
                    if (bus.host_req_in) begin
                        ack <= 1'b1;
                        if (bus.host_sel_in == SEL_RSVD) begin
                            err <= 1'b1;
                        end else begin
                            state    <= ST_HWAIT;
                            cnt      <= 16'd0;
                            trig     <= trig_for(bus.host_sel_in);
                            cmd_addr <= bus.host_addr_in;
                            cmd_data <= bus.host_data_in;
                        end
                    end
                end
                ST_HWAIT: begin
                    if (cnt == SPI_WAIT - 16'd1) begin
                        state <= ST_IDLE;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_DELAY;
                    cnt   <= 16'd0;
                    idx   <= 2'd0;
                end
            endcase
        end
    end

    assign bus.adc1_cmd_trig_out = trig[0];
    assign bus.adc2_cmd_trig_out = trig[1];
    assign bus.dac1_cmd_trig_out = trig[2];
    assign bus.host_ack_out      = ack;
    assign bus.err_out           = err;
    assign bus.init_done_out     = init_done;
    assign bus.cmd_addr_out      = cmd_addr;
    assign bus.cmd_data_out      = cmd_data;
    assign bus.busy_out          = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_sequencer
//
// Self-checking bench for spi_cmd_sequencer with INIT_DELAY=10, SPI_WAIT=20.
// A timeline model derives every output from the cycle number since reset
// release, the init schedule formula and the time the sequencer next becomes
// idle; it is compared on every falling edge. Directed literal checks at
// hand-computed cycles pin the model.
// -----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;

    localparam int ID        = 10;
    localparam int W         = 20;
    localparam int INIT_DONE = ID + 4 * (W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_cmd_sequencer_if bus_if ();

    spi_cmd_sequencer #(
        .INIT_DELAY (16'd10),
        .SPI_WAIT   (16'd20)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    logic [2:0] trig;
    assign trig = {bus_if.dac1_cmd_trig_out, bus_if.adc2_cmd_trig_out, bus_if.adc1_cmd_trig_out};

    int n_compared   = 0;
    int n_mismatched = 0;
    int now          = -2;

    // Power-up table as seen by the converters.
    logic [1:0]  tbl_sel  [4] = '{2'd0, 2'd1, 2'd0, 2'd2};
    logic [15:0] tbl_addr [4] = '{16'h0000, 16'h0000, 16'h0003, 16'h0000};
    logic [15:0] tbl_data [4] = '{16'h0080, 16'h0080, 16'h0001, 16'h0020};

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [1:0] sel, input logic [15:0] addr, input logic [15:0] data);
        bus_if.host_req_in  = req;
        bus_if.host_sel_in  = sel;
        bus_if.host_addr_in = addr;
        bus_if.host_data_in = data;
    endtask

    task automatic runTo(input int t);
        while (now < t) begin
            @(posedge clk);
            #1;
            now++;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        now = -1;
    endtask

    // Timeline model: inputs captured on one falling edge are what the DUT
    // samples on the following rising edge.
    logic        prev_rst  = 1'b1;
    logic        prev_req  = 1'b0;
    logic [1:0]  prev_sel  = 2'd0;
    logic [15:0] prev_addr = 16'd0;
    logic [15:0] prev_data = 16'd0;
    bit          started   = 1'b0;
    int          rel       = -1;
    int          idle_from = INIT_DONE;
    logic [2:0]  e_trig;
    logic        e_ack, e_err, e_done, e_busy;
    logic [15:0] e_addr = 16'd0;
    logic [15:0] e_data = 16'd0;

    always @(negedge clk) begin
        if (prev_rst) begin
            started   = 1'b1;
            rel       = -1;
            idle_from = INIT_DONE;
            e_trig    = 3'b000;
            e_ack     = 1'b0;
            e_err     = 1'b0;
            e_done    = 1'b0;
            e_busy    = 1'b1;
            e_addr    = 16'd0;
            e_data    = 16'd0;
        end else begin
            rel++;
            e_trig = 3'b000;
            e_ack  = 1'b0;
            e_err  = 1'b0;
            if (rel >= ID && rel < INIT_DONE && ((rel - ID) % (W + 1)) == 0) begin
                int k;
                k      = (rel - ID) / (W + 1);
                e_trig = 3'b001 << tbl_sel[k];
                e_addr = tbl_addr[k];
                e_data = tbl_data[k];
            end
            if ((rel - 1) >= idle_from && prev_req) begin
                e_ack = 1'b1;
                if (prev_sel == 2'd3) begin
                    e_err = 1'b1;
                end else begin
                    e_trig    = 3'b001 << prev_sel;
                    e_addr    = prev_addr;
                    e_data    = prev_data;
                    idle_from = rel + W;
                end
            end
            e_done = (rel >= INIT_DONE);
            e_busy = (rel < idle_from);
        end
        if (started) begin
            checkOutput("model_trig", {13'd0, trig}, {13'd0, e_trig});
            checkOutput("model_ack", {15'd0, bus_if.host_ack_out}, {15'd0, e_ack});
            checkOutput("model_err", {15'd0, bus_if.err_out}, {15'd0, e_err});
            checkOutput("model_init_done", {15'd0, bus_if.init_done_out}, {15'd0, e_done});
            checkOutput("model_busy", {15'd0, bus_if.busy_out}, {15'd0, e_busy});
            checkOutput("model_cmd_addr", bus_if.cmd_addr_out, e_addr);
            checkOutput("model_cmd_data", bus_if.cmd_data_out, e_data);
        end
        prev_rst  = rst;
        prev_req  = bus_if.host_req_in;
        prev_sel  = bus_if.host_sel_in;
        prev_addr = bus_if.host_addr_in;
        prev_data = bus_if.host_data_in;
    end

    initial begin
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        now = -1;

        checkOutput("rst_trig", {13'd0, trig}, 16'd0);
        checkOutput("rst_busy", {15'd0, bus_if.busy_out}, 16'd1);
        checkOutput("rst_done", {15'd0, bus_if.init_done_out}, 16'd0);
        checkOutput("rst_addr", bus_if.cmd_addr_out, 16'd0);

        runTo(9);
        checkOutput("c9_no_trig", {13'd0, trig}, 16'd0);
        runTo(10);
        checkOutput("c10_trig", {13'd0, trig}, 16'h0001);
        checkOutput("c10_data", bus_if.cmd_data_out, 16'h0080);
        runTo(31);
        checkOutput("c31_trig", {13'd0, trig}, 16'h0002);
        checkOutput("c31_data", bus_if.cmd_data_out, 16'h0080);
        runTo(40);
        applyStimulus(1'b1, 2'd0, 16'h0042, 16'h1234);
        runTo(52);
        checkOutput("c52_trig", {13'd0, trig}, 16'h0001);
        checkOutput("c52_addr", bus_if.cmd_addr_out, 16'h0003);
        checkOutput("c52_data", bus_if.cmd_data_out, 16'h0001);
        checkOutput("c52_no_ack", {15'd0, bus_if.host_ack_out}, 16'd0);
        runTo(73);
        checkOutput("c73_trig", {13'd0, trig}, 16'h0004);
        checkOutput("c73_data", bus_if.cmd_data_out, 16'h0020);
        runTo(93);
        checkOutput("c93_done", {15'd0, bus_if.init_done_out}, 16'd0);
        checkOutput("c93_busy", {15'd0, bus_if.busy_out}, 16'd1);
        runTo(94);
        checkOutput("c94_done", {15'd0, bus_if.init_done_out}, 16'd1);
        checkOutput("c94_busy", {15'd0, bus_if.busy_out}, 16'd0);
        checkOutput("c94_no_ack", {15'd0, bus_if.host_ack_out}, 16'd0);
        runTo(95);
        checkOutput("c95_ack", {15'd0, bus_if.host_ack_out}, 16'd1);
        checkOutput("c95_trig", {13'd0, trig}, 16'h0001);
        checkOutput("c95_addr", bus_if.cmd_addr_out, 16'h0042);
        checkOutput("c95_data", bus_if.cmd_data_out, 16'h1234);

        applyStimulus(1'b1, 2'd1, 16'h0007, 16'h5678);
        runTo(115);
        checkOutput("c115_busy", {15'd0, bus_if.busy_out}, 16'd0);
        checkOutput("c115_no_trig", {13'd0, trig}, 16'd0);
        runTo(116);
        checkOutput("c116_trig", {13'd0, trig}, 16'h0002);
        checkOutput("c116_addr", bus_if.cmd_addr_out, 16'h0007);
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);

        runTo(140);
        applyStimulus(1'b1, 2'd2, 16'h0015, 16'hBEEF);
        runTo(141);
        checkOutput("c141_ack", {15'd0, bus_if.host_ack_out}, 16'd1);
        checkOutput("c141_trig", {13'd0, trig}, 16'h0004);
        checkOutput("c141_addr", bus_if.cmd_addr_out, 16'h0015);
        checkOutput("c141_data", bus_if.cmd_data_out, 16'hBEEF);
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
        runTo(160);
        checkOutput("c160_busy", {15'd0, bus_if.busy_out}, 16'd1);
        runTo(161);
        checkOutput("c161_busy", {15'd0, bus_if.busy_out}, 16'd0);

        runTo(170);
        applyStimulus(1'b1, 2'd3, 16'hAAAA, 16'h5555);
        runTo(171);
        checkOutput("c171_ack", {15'd0, bus_if.host_ack_out}, 16'd1);
        checkOutput("c171_err", {15'd0, bus_if.err_out}, 16'd1);
        checkOutput("c171_trig", {13'd0, trig}, 16'd0);
        checkOutput("c171_data", bus_if.cmd_data_out, 16'hBEEF);
        checkOutput("c171_busy", {15'd0, bus_if.busy_out}, 16'd0);
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
        runTo(172);
        checkOutput("c172_err", {15'd0, bus_if.err_out}, 16'd0);

        runTo(180);
        doReset();
        checkOutput("idle_rst_done", {15'd0, bus_if.init_done_out}, 16'd0);
        checkOutput("idle_rst_addr", bus_if.cmd_addr_out, 16'd0);

        runTo(60);
        doReset();
        checkOutput("wait_rst_trig", {13'd0, trig}, 16'd0);
        checkOutput("wait_rst_busy", {15'd0, bus_if.busy_out}, 16'd1);
        runTo(10);
        checkOutput("replay_c10_trig", {13'd0, trig}, 16'h0001);
        runTo(100);
        checkOutput("replay_done", {15'd0, bus_if.init_done_out}, 16'd1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
